// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use, mul/div scoreboard and branch-squash control
// for the ID stage. It drives the PC, IF/ID and ID/EX register enables.
module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] IDregR1,
  input  logic [3:0] IDregR2,
  input  logic       IDuseR1,
  input  logic       IDuseR2,
  input  logic [3:0] IDregRd,
  input  logic       IDregWrite,
  input  logic       IDvalid,
  input  logic       IDmulDiv,
  input  logic       EXmemRead,
  input  logic [3:0] EXregRd,
  input  logic       EXbranchTaken,
  output logic       pcWrite,
  output logic       ifidWrite,
  output logic       ifidFlush,
  output logic       idexBubble,
  output logic       mdIssue,
  output logic       mdBusy,
  output logic       mdDone
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_pending, w_pending_nxt;

  logic w_lu, w_raw, w_waw, w_str, w_stall;

  // pending[0] is never set, so register 0 can never raise a scoreboard hazard
  assign w_lu    = EXmemRead && (EXregRd != 4'd0) &&
                   ((IDuseR1 && (IDregR1 == EXregRd)) || (IDuseR2 && (IDregR2 == EXregRd)));
  assign w_raw   = (IDuseR1 && r_pending[IDregR1]) || (IDuseR2 && r_pending[IDregR2]);
  assign w_waw   = IDregWrite && r_pending[IDregRd];
  assign w_str   = IDmulDiv && (r_state == BUSY);
  assign w_stall = IDvalid && !EXbranchTaken && (w_lu || w_raw || w_waw || w_str);

  assign mdBusy = (r_state == BUSY);
  assign mdDone = (r_state == BUSY) && (r_cnt == 4'd0);

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    mdIssue    = 1'b0;
    if (EXbranchTaken) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (w_stall) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end else if (IDvalid && IDmulDiv) begin
      mdIssue = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    if (r_state == BUSY) begin
      if (r_cnt == 4'd0) begin
        w_state_nxt   = IDLE;
        w_pending_nxt = 16'd0;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
    end
    // Issue is only possible from IDLE: a mul/div in ID while BUSY is a structural stall
    if (mdIssue) begin
      w_state_nxt = BUSY;
      w_cnt_nxt   = 4'(MD_LAT - 1);
      if (IDregRd != 4'd0) w_pending_nxt[IDregRd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_pending <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LAT=4): expected output vectors are queued as each
// step is driven and compared against the DUT when the step is sampled.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] IDregR1, IDregR2, IDregRd, EXregRd;
  logic       IDuseR1, IDuseR2, IDregWrite, IDvalid, IDmulDiv, EXmemRead, EXbranchTaken;
  logic       pcWrite, ifidWrite, ifidFlush, idexBubble, mdIssue, mdBusy, mdDone;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  string      tag_q[$];

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDregR1(IDregR1), .IDregR2(IDregR2), .IDuseR1(IDuseR1), .IDuseR2(IDuseR2),
    .IDregRd(IDregRd), .IDregWrite(IDregWrite), .IDvalid(IDvalid), .IDmulDiv(IDmulDiv),
    .EXmemRead(EXmemRead), .EXregRd(EXregRd), .EXbranchTaken(EXbranchTaken),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexBubble(idexBubble), .mdIssue(mdIssue), .mdBusy(mdBusy), .mdDone(mdDone)
  );

  always #5 clk = ~clk;

  // Vector order: {pcWrite, ifidWrite, ifidFlush, idexBubble, mdIssue, mdBusy, mdDone}
  localparam logic [6:0] V_IDLE   = 7'b1100000;
  localparam logic [6:0] V_ISSUE  = 7'b1100100;
  localparam logic [6:0] V_BUSY   = 7'b1100010;
  localparam logic [6:0] V_DONE   = 7'b1100011;
  localparam logic [6:0] V_STALL  = 7'b0001000;
  localparam logic [6:0] V_STALLB = 7'b0001010;
  localparam logic [6:0] V_STALLD = 7'b0001011;

  task automatic idle_in();
    IDregR1 = 4'd0; IDregR2 = 4'd0; IDuseR1 = 1'b0; IDuseR2 = 1'b0;
    IDregRd = 4'd0; IDregWrite = 1'b0; IDvalid = 1'b0; IDmulDiv = 1'b0;
    EXmemRead = 1'b0; EXregRd = 4'd0; EXbranchTaken = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic mul_in(input logic [3:0] rd);
    IDvalid = 1'b1; IDmulDiv = 1'b1; IDregWrite = 1'b1; IDregRd = rd;
  endtask

  task automatic add_in(input logic [3:0] r1, input logic [3:0] rd);
    IDvalid = 1'b1; IDuseR1 = 1'b1; IDregR1 = r1; IDregWrite = 1'b1; IDregRd = rd;
  endtask

  task automatic chk(input logic [6:0] exp, input string tag, input bit now);
    logic [6:0] obs, e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    if (now) #1;
    else @(negedge clk);
    obs = {pcWrite, ifidWrite, ifidFlush, idexBubble, mdIssue, mdBusy, mdDone};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %b with no expected entry queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", t, obs, e);
      end
    end
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    #2;
    chk(V_IDLE, "reset_state", 1);
    #9 rst_n = 1'b1;

    // Load-use: one-cycle stall, then the load has left EX
    next_cycle(); add_in(4'd5, 4'd6); EXmemRead = 1'b1; EXregRd = 4'd5;
    chk(V_STALL, "lu_stall", 0);
    next_cycle(); add_in(4'd5, 4'd6);
    chk(V_IDLE, "lu_release", 0);
    next_cycle(); add_in(4'd0, 4'd6); EXmemRead = 1'b1; EXregRd = 4'd0;
    chk(V_IDLE, "lu_reg0", 0);
    next_cycle(); IDuseR2 = 1'b1; IDregR2 = 4'd5; EXmemRead = 1'b1; EXregRd = 4'd5;
    chk(V_IDLE, "lu_not_valid", 0);
    next_cycle(); IDvalid = 1'b1; IDuseR2 = 1'b1; IDregR2 = 4'd5; EXmemRead = 1'b1; EXregRd = 4'd5;
    chk(V_STALL, "lu_stall_r2", 0);

    // MUL r7 issue at cycle 0; independent, WAW and RAW followers
    next_cycle(); mul_in(4'd7); IDuseR1 = 1'b1; IDregR1 = 4'd1;
    chk(V_ISSUE, "md_issue", 0);
    next_cycle(); add_in(4'd3, 4'd8);
    chk(V_BUSY, "raw_r3_nostall", 0);
    next_cycle(); IDvalid = 1'b1; IDregWrite = 1'b1; IDregRd = 4'd7;
    chk(V_STALLB, "waw_r7", 0);
    next_cycle(); add_in(4'd7, 4'd8);
    chk(V_STALLB, "raw_r7_c3", 0);
    next_cycle(); add_in(4'd7, 4'd8);
    chk(V_STALLD, "raw_r7_done", 0);
    next_cycle(); add_in(4'd7, 4'd8);
    chk(V_IDLE, "raw_r7_proceed", 0);

    // Back-to-back MULs: second issues the cycle after mdDone
    next_cycle(); mul_in(4'd7);
    chk(V_ISSUE, "b2b_issue1", 0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); mul_in(4'd9);
      chk(V_STALLB, $sformatf("b2b_stall_c%0d", i), 0);
    end
    next_cycle(); mul_in(4'd9);
    chk(V_STALLD, "b2b_stall_done", 0);
    next_cycle(); mul_in(4'd9);
    chk(V_ISSUE, "b2b_issue2", 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); IDmulDiv = 1'b1;
      chk(V_BUSY, $sformatf("b2b_busy_%0d", i), 0);
    end
    next_cycle();
    chk(V_DONE, "b2b_done2", 0);
    next_cycle(); add_in(4'd9, 4'd2);
    chk(V_IDLE, "b2b_r9_free", 0);

    // Taken branch overrides load-use, RAW and structural hazards
    next_cycle(); mul_in(4'd7);
    chk(V_ISSUE, "br_issue", 0);
    next_cycle(); add_in(4'd7, 4'd7); IDmulDiv = 1'b1;
    EXmemRead = 1'b1; EXregRd = 4'd7; EXbranchTaken = 1'b1;
    chk(7'b1111010, "br_override", 0);
    next_cycle();
    chk(V_BUSY, "br_busy_c2", 0);
    next_cycle();
    chk(V_BUSY, "br_busy_c3", 0);
    next_cycle();
    chk(V_DONE, "br_done_sched", 0);
    next_cycle();
    chk(V_IDLE, "br_after", 0);

    // Reset mid-operation
    next_cycle(); mul_in(4'd7);
    chk(V_ISSUE, "rst_issue", 0);
    next_cycle();
    chk(V_BUSY, "rst_busy_c1", 0);
    next_cycle();
    #1 rst_n = 1'b0;
    chk(V_IDLE, "rst_async", 1);
    add_in(4'd7, 4'd8);
    chk(V_IDLE, "rst_pending_clr", 1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); add_in(4'd7, 4'd7);
      chk(V_IDLE, $sformatf("rst_no_done_%0d", i), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
